wb_regfile: RTL and testbench



---
 rtl/wb_regfile.sv | 127 ++++++++++++
 tb/tb_wb_regfile.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// ---------------------------------------------------------------------------
// wb_regfile
//   MEM/WB pipeline register plus a 32 x 32 general register file.
//   The MEM stage result is captured into the MEM/WB register, with stall and
//   flush control. It is committed to the register file on the next edge.
//   Two combinational decode read ports bypass the pending WB write, so a read
//   never returns a value that is about to be overwritten.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   stall               hold the MEM/WB register
//   flush               clear the MEM/WB register (bubble); overrides stall
//   reg_write_*_i       MEM stage write data / address / enable
//   raddrN_i, reN_i     read port N address and enable (N = 1, 2)
//   rdataN_o            read port N data, combinational
//   wb_*_o              MEM/WB register contents
// ---------------------------------------------------------------------------
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREG   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic [DATA_W-1:0] reg_write_data_i,
    input  logic [ADDR_W-1:0] reg_write_addr_i,
    input  logic              reg_write_en_i,
    input  logic [ADDR_W-1:0] raddr1_i,
    input  logic              re1_i,
    output logic [DATA_W-1:0] rdata1_o,
    input  logic [ADDR_W-1:0] raddr2_i,
    input  logic              re2_i,
    output logic [DATA_W-1:0] rdata2_o,
    output logic [DATA_W-1:0] wb_data_o,
    output logic [ADDR_W-1:0] wb_addr_o,
    output logic              wb_en_o
);

    logic [DATA_W-1:0] wb_data_r;
    logic [ADDR_W-1:0] wb_addr_r;
    logic              wb_en_r;
    logic [DATA_W-1:0] regs_r [0:NREG-1];

    logic [DATA_W-1:0] rdata1_s;
    logic [DATA_W-1:0] rdata2_s;

    // One read port's value.
    // A disabled port reads 0, and so does r0.
    // A hit on the pending WB entry returns that data, because the entry
    // lands in the array only at the next edge.
    function automatic logic [DATA_W-1:0] read_port(
        input logic              re,
        input logic [ADDR_W-1:0] addr,
        input logic              pend_en,
        input logic [ADDR_W-1:0] pend_addr,
        input logic [DATA_W-1:0] pend_data,
        input logic [DATA_W-1:0] array_val
    );
        logic [DATA_W-1:0] val;
        if (!re || (addr == {ADDR_W{1'b0}})) begin
            val = {DATA_W{1'b0}};
        end else if (pend_en && (pend_addr == addr)) begin
            val = pend_data;
        end else begin
            val = array_val;
        end
        return val;
    endfunction

    // MEM/WB pipeline register.
    // Priority is reset, then flush (which beats stall), then stall, then capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_en_r   <= 1'b0;
            wb_addr_r <= {ADDR_W{1'b0}};
            wb_data_r <= {DATA_W{1'b0}};
        end else if (flush) begin
            wb_en_r   <= 1'b0;
            wb_addr_r <= {ADDR_W{1'b0}};
            wb_data_r <= {DATA_W{1'b0}};
        end else if (stall) begin
            wb_en_r   <= wb_en_r;
            wb_addr_r <= wb_addr_r;
            wb_data_r <= wb_data_r;
        end else begin
            wb_en_r   <= reg_write_en_i;
            wb_addr_r <= reg_write_addr_i;
            wb_data_r <= reg_write_data_i;
        end
    end

    // Register file commit from the WB stage.
    // During a stall, the same entry is rewritten on each stalled edge. This is
    // harmless because the data does not change.
    // The address range check guards builds where NREG < 2**ADDR_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else if (wb_en_r && (wb_addr_r != {ADDR_W{1'b0}})
                     && (int'(wb_addr_r) < NREG)) begin
            regs_r[wb_addr_r] <= wb_data_r;
        end else begin
            regs_r[0] <= {DATA_W{1'b0}};
        end
    end

    // Decode read ports: zero-latency, with bypass from the pending WB entry.
    always_comb begin
        rdata1_s = {DATA_W{1'b0}};
        rdata2_s = {DATA_W{1'b0}};
        rdata1_s = read_port(re1_i, raddr1_i, wb_en_r, wb_addr_r, wb_data_r,
                             regs_r[raddr1_i]);
        rdata2_s = read_port(re2_i, raddr2_i, wb_en_r, wb_addr_r, wb_data_r,
                             regs_r[raddr2_i]);
    end

    assign rdata1_o  = rdata1_s;
    assign rdata2_o  = rdata2_s;
    assign wb_data_o = wb_data_r;
    assign wb_addr_o = wb_addr_r;
    assign wb_en_o   = wb_en_r;

endmodule

// File: tb/tb_wb_regfile.sv
// ---------------------------------------------------------------------------
// tb_wb_regfile
//   Self-checking bench for wb_regfile.
//   - A table of hand-derived vectors covers the directed scenarios.
//   - A full-array readback follows the table.
//   - Randomized traffic is checked against a reference model.
//   - A final reset check runs after random writes.
// ---------------------------------------------------------------------------
module tb_wb_regfile;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [31:0] reg_write_data_i;
    logic [4:0]  reg_write_addr_i;
    logic        reg_write_en_i;
    logic [4:0]  raddr1_i;
    logic        re1_i;
    logic [31:0] rdata1_o;
    logic [4:0]  raddr2_i;
    logic        re2_i;
    logic [31:0] rdata2_o;
    logic [31:0] wb_data_o;
    logic [4:0]  wb_addr_o;
    logic        wb_en_o;

    int n_cmp;
    int n_bad;

    // Reference model: architectural register contents plus the one pending
    // write that becomes architectural at the next edge.
    logic [31:0] m_regs [0:31];
    logic        m_pend_en;
    logic [4:0]  m_pend_addr;
    logic [31:0] m_pend_data;

    wb_regfile dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .flush            (flush),
        .reg_write_data_i (reg_write_data_i),
        .reg_write_addr_i (reg_write_addr_i),
        .reg_write_en_i   (reg_write_en_i),
        .raddr1_i         (raddr1_i),
        .re1_i            (re1_i),
        .rdata1_o         (rdata1_o),
        .raddr2_i         (raddr2_i),
        .re2_i            (re2_i),
        .rdata2_o         (rdata2_o),
        .wb_data_o        (wb_data_o),
        .wb_addr_o        (wb_addr_o),
        .wb_en_o          (wb_en_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        flush;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        re1;
        logic [4:0]  ra1;
        logic        re2;
        logic [4:0]  ra2;
        logic [31:0] e_rd1;   // read data before the edge
        logic [31:0] e_rd2;
        logic        e_en;    // MEM/WB contents after the edge
        logic [4:0]  e_addr;
        logic [31:0] e_data;
    } vec_t;

    localparam int NVEC = 27;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic re, input logic [4:0] a);
        if (!re || a == 5'd0) return 32'd0;
        if (m_pend_en && m_pend_addr == a) return m_pend_data;
        return m_regs[a];
    endfunction

    // Apply the clock-edge rules, using the inputs present at that edge.
    task automatic model_edge();
        if (rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            m_pend_en   = 1'b0;
            m_pend_addr = 5'd0;
            m_pend_data = 32'd0;
        end else begin
            if (m_pend_en && m_pend_addr != 5'd0) m_regs[m_pend_addr] = m_pend_data;
            if (flush) begin
                m_pend_en   = 1'b0;
                m_pend_addr = 5'd0;
                m_pend_data = 32'd0;
            end else if (!stall) begin
                m_pend_en   = reg_write_en_i;
                m_pend_addr = reg_write_addr_i;
                m_pend_data = reg_write_data_i;
            end
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic f,
                         input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic e1, input logic [4:0] a1,
                         input logic e2, input logic [4:0] a2);
        rst = r; stall = s; flush = f;
        reg_write_en_i = we; reg_write_addr_i = wa; reg_write_data_i = wd;
        re1_i = e1; raddr1_i = a1; re2_i = e2; raddr2_i = a2;
    endtask

    // Advance one clock edge, keep the model in step, then settle past the edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic readback_all(input string tag, input logic zero_expected);
        logic [31:0] e;
        for (int i = 0; i < 32; i++) begin
            re1_i = 1'b1; raddr1_i = 5'(i);
            re2_i = 1'b1; raddr2_i = 5'(i);
            #1;
            e = zero_expected ? 32'd0 : model_read(1'b1, 5'(i));
            check($sformatf("%s_p1_r%0d", tag, i), rdata1_o, e);
            check($sformatf("%s_p2_r%0d", tag, i), rdata2_o, e);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_pend_en = 1'b0; m_pend_addr = 5'd0; m_pend_data = 32'd0;

        //          rst   stl   fl    we    wa     wd             e1    a1     e2    a2     rd1            rd2            en    addr   data
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 5'd5,  1'b1, 5'd0,  32'h0,         32'h0,         1'b1, 5'd5,  32'hDEADBEEF};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  1'b1, 5'd5,  32'hDEADBEEF,  32'hDEADBEEF,  1'b0, 5'd0,  32'h0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  1'b0, 5'd5,  32'hDEADBEEF,  32'h0,         1'b0, 5'd0,  32'h0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 5'd0,  32'hFFFFFFFF, 1'b1, 5'd0,  1'b1, 5'd0,  32'h0,         32'h0,         1'b1, 5'd0,  32'hFFFFFFFF};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  1'b1, 5'd0,  32'h0,         32'h0,         1'b0, 5'd0,  32'h0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  1'b1, 5'd0,  32'h0,         32'h0,         1'b0, 5'd0,  32'h0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 5'd7,  32'h11,       1'b1, 5'd7,  1'b1, 5'd7,  32'h0,         32'h0,         1'b1, 5'd7,  32'h11};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 5'd7,  32'h22,       1'b1, 5'd7,  1'b1, 5'd7,  32'h11,        32'h11,        1'b1, 5'd7,  32'h22};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 5'd7,  32'h33,       1'b1, 5'd7,  1'b1, 5'd7,  32'h22,        32'h22,        1'b1, 5'd7,  32'h33};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  1'b0, 5'd7,  32'h33,        32'h0,         1'b0, 5'd0,  32'h0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 5'd3,  32'hAA,       1'b1, 5'd3,  1'b1, 5'd4,  32'h0,         32'h0,         1'b1, 5'd3,  32'hAA};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 5'd4,  32'hBB,       1'b1, 5'd3,  1'b1, 5'd4,  32'hAA,        32'h0,         1'b1, 5'd3,  32'hAA};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 5'd4,  32'hBB,       1'b1, 5'd3,  1'b1, 5'd4,  32'hAA,        32'h0,         1'b1, 5'd3,  32'hAA};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 5'd4,  32'hBB,       1'b1, 5'd3,  1'b1, 5'd4,  32'hAA,        32'h0,         1'b1, 5'd3,  32'hAA};
        vecs[14] = '{1'b0, 1'b1, 1'b1, 1'b1, 5'd4,  32'hBB,       1'b1, 5'd3,  1'b1, 5'd4,  32'hAA,        32'h0,         1'b0, 5'd0,  32'h0};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  1'b1, 5'd4,  32'hAA,        32'h0,         1'b0, 5'd0,  32'h0};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 5'd9,  32'h1,        1'b1, 5'd9,  1'b0, 5'd0,  32'h0,         32'h0,         1'b1, 5'd9,  32'h1};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b1, 5'd9,  32'h2,        1'b1, 5'd9,  1'b0, 5'd0,  32'h1,         32'h0,         1'b1, 5'd9,  32'h2};
        vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b1, 5'd9,  32'h3,        1'b1, 5'd9,  1'b0, 5'd0,  32'h2,         32'h0,         1'b1, 5'd9,  32'h3};
        vecs[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  1'b0, 5'd0,  32'h3,         32'h0,         1'b0, 5'd0,  32'h0};
        vecs[20] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  1'b1, 5'd9,  32'h3,         32'h3,         1'b0, 5'd0,  32'h0};
        vecs[21] = '{1'b0, 1'b0, 1'b0, 1'b1, 5'd12, 32'h55,       1'b1, 5'd3,  1'b1, 5'd9,  32'hAA,        32'h3,         1'b1, 5'd12, 32'h55};
        vecs[22] = '{1'b1, 1'b1, 1'b0, 1'b1, 5'd13, 32'h66,       1'b1, 5'd12, 1'b1, 5'd3,  32'h55,        32'hAA,        1'b0, 5'd0,  32'h0};
        vecs[23] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd12, 1'b1, 5'd3,  32'h0,         32'h0,         1'b0, 5'd0,  32'h0};
        vecs[24] = '{1'b0, 1'b0, 1'b0, 1'b1, 5'd20, 32'h77,       1'b1, 5'd20, 1'b1, 5'd21, 32'h0,         32'h0,         1'b1, 5'd20, 32'h77};
        vecs[25] = '{1'b0, 1'b0, 1'b1, 1'b1, 5'd21, 32'h88,       1'b1, 5'd20, 1'b1, 5'd21, 32'h77,        32'h0,         1'b0, 5'd0,  32'h0};
        vecs[26] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd20, 1'b1, 5'd21, 32'h77,        32'h0,         1'b0, 5'd0,  32'h0};

        // Initial reset, then check the reset state.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        #1;
        tick();
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        check("rst_wb_en",   {31'd0, wb_en_o}, 32'd0);
        check("rst_wb_addr", {27'd0, wb_addr_o}, 32'd0);
        check("rst_wb_data", wb_data_o, 32'd0);

        // Directed table.
        for (int k = 0; k < NVEC; k++) begin
            drive(vecs[k].rst, vecs[k].stall, vecs[k].flush, vecs[k].we, vecs[k].wa,
                  vecs[k].wd, vecs[k].re1, vecs[k].ra1, vecs[k].re2, vecs[k].ra2);
            #1;
            check($sformatf("v%0d_rd1", k), rdata1_o, vecs[k].e_rd1);
            check($sformatf("v%0d_rd2", k), rdata2_o, vecs[k].e_rd2);
            tick();
            check($sformatf("v%0d_wb_en", k),   {31'd0, wb_en_o},   {31'd0, vecs[k].e_en});
            check($sformatf("v%0d_wb_addr", k), {27'd0, wb_addr_o}, {27'd0, vecs[k].e_addr});
            check($sformatf("v%0d_wb_data", k), wb_data_o,          vecs[k].e_data);
        end

        // Full readback after the table (r0 must still read 0).
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 1'b1, 5'd0);
        readback_all("tbl_rb", 1'b0);
        check("tbl_r20_committed", model_read(1'b1, 5'd20), 32'h77);

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            logic [4:0] a1, a2;
            a1 = ($urandom_range(3) == 0) ? m_pend_addr : 5'($urandom_range(31));
            a2 = ($urandom_range(3) == 0) ? m_pend_addr : 5'($urandom_range(31));
            drive(1'b0, ($urandom_range(7) == 0), ($urandom_range(11) == 0),
                  ($urandom_range(3) != 0), 5'($urandom_range(31)), $urandom,
                  ($urandom_range(7) != 0), a1, ($urandom_range(7) != 0), a2);
            #1;
            check($sformatf("rnd%0d_rd1", c), rdata1_o, model_read(re1_i, raddr1_i));
            check($sformatf("rnd%0d_rd2", c), rdata2_o, model_read(re2_i, raddr2_i));
            tick();
            check($sformatf("rnd%0d_wb_en", c),   {31'd0, wb_en_o},   {31'd0, m_pend_en});
            check($sformatf("rnd%0d_wb_addr", c), {27'd0, wb_addr_o}, {27'd0, m_pend_addr});
            check($sformatf("rnd%0d_wb_data", c), wb_data_o,          m_pend_data);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 1'b1, 5'd0);
        readback_all("rnd_rb", 1'b0);

        // Reset with a write pending: every register reads 0 and the MEM/WB
        // register is cleared.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 5'd17, 32'hCAFE0001, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        drive(1'b1, 1'b1, 1'b0, 1'b1, 5'd18, 32'hCAFE0002, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 1'b1, 5'd0);
        check("rst2_wb_en",   {31'd0, wb_en_o}, 32'd0);
        check("rst2_wb_addr", {27'd0, wb_addr_o}, 32'd0);
        check("rst2_wb_data", wb_data_o, 32'd0);
        readback_all("rst2_rb", 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
